// File: rtl/calc_pkg.sv
// Shared types for the calc2 port driver: command/response encodings, tag and packet types.
package calc_pkg;

    localparam int TAG_SLOTS = 4;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE   = 2'd0,
        RESP_OK     = 2'd1,
        RESP_ERR    = 2'd2,
        RESP_UNUSED = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND1,
        ST_SEND2
    } state_e;

    typedef logic [1:0] tag_t;

    // cmd is kept as raw bits so unlisted encodings still pass through untouched
    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
    } pkt_t;

endpackage

// File: rtl/calc_tag_table.sv
// Per-tag busy flags, stored packets and age timers, plus lowest-free and lowest-expired encoders.
module calc_tag_table
    import calc_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                 c_clk,
    input  logic                 reset,
    input  logic                 i_alloc,
    input  pkt_t                 i_allocPkt,
    input  logic                 i_free,
    input  tag_t                 i_freeTag,
    input  tag_t                 i_rdTag,
    output pkt_t                 o_rdPkt,
    output logic [TAG_SLOTS-1:0] o_busy,
    output logic                 o_freeValid,
    output tag_t                 o_freeTag,
    output logic                 o_expValid,
    output tag_t                 o_expTag
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TAG_SLOTS-1:0] r_busy;
    pkt_t                 r_pkt   [TAG_SLOTS];
    logic [TW-1:0]        r_timer [TAG_SLOTS];

    assign o_busy  = r_busy;
    assign o_rdPkt = r_pkt[i_rdTag];

    // Descending scans so the lowest qualifying index is the last one written
    always_comb begin
        o_freeValid = 1'b0;
        o_freeTag   = '0;
        o_expValid  = 1'b0;
        o_expTag    = '0;
        for (int i = TAG_SLOTS - 1; i >= 0; i--) begin
            if (i < MAX_OUTST && !r_busy[i]) begin
                o_freeValid = 1'b1;
                o_freeTag   = tag_t'(i);
            end
            if (r_busy[i] && r_timer[i] == TW'(TIMEOUT)) begin
                o_expValid = 1'b1;
                o_expTag   = tag_t'(i);
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
            for (int i = 0; i < TAG_SLOTS; i++) begin
                r_pkt[i]   <= '0;
                r_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAG_SLOTS; i++) begin
                if (i_alloc && o_freeTag == tag_t'(i)) begin
                    r_busy[i]  <= 1'b1;
                    r_pkt[i]   <= i_allocPkt;
                    r_timer[i] <= '0;
                end else begin
                    if (i_free && i_freeTag == tag_t'(i)) begin
                        r_busy[i] <= 1'b0;
                    end
                    if (r_busy[i] && r_timer[i] != TW'(TIMEOUT)) begin
                        r_timer[i] <= r_timer[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/calc_port_driver.sv
// Request driver for one calc2 port: tags packets, serialises them as two-beat requests,
// and turns tagged DUT responses or timeouts into one completion per packet.
module calc_port_driver
    import calc_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cmd,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    output logic [1:0]  req_tag_out,
    input  logic [1:0]  resp_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  tag_in,
    output logic        cpl_valid,
    output logic [1:0]  cpl_tag,
    output logic [3:0]  cpl_cmd,
    output logic [31:0] cpl_op1,
    output logic [31:0] cpl_op2,
    output logic [1:0]  cpl_resp,
    output logic [31:0] cpl_data,
    output logic        cpl_timeout,
    output logic        err_unexp,
    output logic        err_timeout,
    output logic [2:0]  outstanding
);

    state_e               r_state, w_nextState;
    logic [3:0]           r_reqCmd, w_nextReqCmd;
    logic [31:0]          r_reqData, w_nextReqData;
    tag_t                 r_reqTag, w_nextReqTag;
    logic [31:0]          r_pendOp2;

    logic [TAG_SLOTS-1:0] w_busy;
    logic                 w_freeValid, w_expValid;
    tag_t                 w_allocTag, w_expTag, w_releaseTag;
    pkt_t                 w_allocPkt, w_rdPkt;
    logic                 w_accept, w_respValid, w_respUnexp, w_retire, w_release;

    logic                 r_cplValid, r_cplTimeout, r_errUnexp, r_errTimeout;
    tag_t                 r_cplTag;
    logic [1:0]           r_cplResp;
    logic [31:0]          r_cplData;
    pkt_t                 r_cplPkt;

    // Gating with reset keeps in_ready low while the block is held in reset
    assign in_ready   = reset && (r_state != ST_SEND1) && w_freeValid;
    assign w_accept   = in_valid && in_ready;
    assign w_allocPkt = '{cmd: in_cmd, op1: in_op1, op2: in_op2};

    // A real response always wins the single completion slot; expired tags wait their turn
    assign w_respValid  = (resp_in == RESP_OK || resp_in == RESP_ERR) && w_busy[tag_in];
    assign w_respUnexp  = (resp_in != RESP_NONE) && !w_respValid;
    assign w_retire     = !w_respValid && w_expValid;
    assign w_release    = w_respValid || w_retire;
    assign w_releaseTag = w_respValid ? tag_in : w_expTag;

    calc_tag_table #(
        .MAX_OUTST (MAX_OUTST),
        .TIMEOUT   (TIMEOUT)
    ) u_tagTable (
        .c_clk       (c_clk),
        .reset       (reset),
        .i_alloc     (w_accept),
        .i_allocPkt  (w_allocPkt),
        .i_free      (w_release),
        .i_freeTag   (w_releaseTag),
        .i_rdTag     (w_releaseTag),
        .o_rdPkt     (w_rdPkt),
        .o_busy      (w_busy),
        .o_freeValid (w_freeValid),
        .o_freeTag   (w_allocTag),
        .o_expValid  (w_expValid),
        .o_expTag    (w_expTag)
    );

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_reqCmd  <= '0;
            r_reqData <= '0;
            r_reqTag  <= '0;
            r_pendOp2 <= '0;
        end else begin
            r_state   <= w_nextState;
            r_reqCmd  <= w_nextReqCmd;
            r_reqData <= w_nextReqData;
            r_reqTag  <= w_nextReqTag;
            if (w_accept) begin
                r_pendOp2 <= in_op2;
            end
        end
    end

    // An accept is only possible outside SEND1, so it can override IDLE and SEND2 alike
    always_comb begin
        w_nextState   = ST_IDLE;
        w_nextReqCmd  = '0;
        w_nextReqData = '0;
        w_nextReqTag  = '0;
        if (r_state == ST_SEND1) begin
            w_nextState   = ST_SEND2;
            w_nextReqData = r_pendOp2;
        end
        if (w_accept) begin
            w_nextState   = ST_SEND1;
            w_nextReqCmd  = in_cmd;
            w_nextReqData = in_op1;
            w_nextReqTag  = w_allocTag;
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_cplValid   <= 1'b0;
            r_cplTag     <= '0;
            r_cplPkt     <= '0;
            r_cplResp    <= '0;
            r_cplData    <= '0;
            r_cplTimeout <= 1'b0;
            r_errUnexp   <= 1'b0;
            r_errTimeout <= 1'b0;
        end else begin
            r_cplValid <= w_release;
            if (w_release) begin
                r_cplTag     <= w_releaseTag;
                r_cplPkt     <= w_rdPkt;
                r_cplResp    <= w_respValid ? resp_in : 2'd0;
                r_cplData    <= w_respValid ? data_in : 32'd0;
                r_cplTimeout <= w_retire;
            end
            if (w_respUnexp) begin
                r_errUnexp <= 1'b1;
            end
            if (w_retire) begin
                r_errTimeout <= 1'b1;
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < TAG_SLOTS; i++) begin
            outstanding = outstanding + {2'b00, w_busy[i]};
        end
    end

    assign req_cmd_out  = r_reqCmd;
    assign req_data_out = r_reqData;
    assign req_tag_out  = r_reqTag;
    assign cpl_valid    = r_cplValid;
    assign cpl_tag      = r_cplTag;
    assign cpl_cmd      = r_cplPkt.cmd;
    assign cpl_op1      = r_cplPkt.op1;
    assign cpl_op2      = r_cplPkt.op2;
    assign cpl_resp     = r_cplResp;
    assign cpl_data     = r_cplData;
    assign cpl_timeout  = r_cplTimeout;
    assign err_unexp    = r_errUnexp;
    assign err_timeout  = r_errTimeout;

endmodule

// File: tb/tb_calc_port_driver.sv
// Bench for calc_port_driver: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a queue/array model of the port's packet bookkeeping.
module tb_calc_port_driver;

    localparam int TIMEOUT = 8;
    localparam int NTAGS   = 4;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [3:0]  in_cmd;
    logic [31:0] in_op1, in_op2;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  req_tag_out;
    logic [1:0]  resp_in;
    logic [31:0] data_in;
    logic [1:0]  tag_in;
    logic        cpl_valid, cpl_timeout, err_unexp, err_timeout;
    logic [1:0]  cpl_tag, cpl_resp;
    logic [3:0]  cpl_cmd;
    logic [31:0] cpl_op1, cpl_op2, cpl_data;
    logic [2:0]  outstanding;

    int assertCount = 0;
    int failCount   = 0;

    calc_port_driver #(.MAX_OUTST(4), .TIMEOUT(TIMEOUT)) dut (
        .c_clk(c_clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
        .resp_in(resp_in), .data_in(data_in), .tag_in(tag_in),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_cmd(cpl_cmd), .cpl_op1(cpl_op1),
        .cpl_op2(cpl_op2), .cpl_resp(cpl_resp), .cpl_data(cpl_data), .cpl_timeout(cpl_timeout),
        .err_unexp(err_unexp), .err_timeout(err_timeout), .outstanding(outstanding)
    );

    always #5 c_clk = ~c_clk;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] data;
        logic [1:0]  tag;
    } beat_t;

    // Model: per-tag packet store and unbounded age, plus a queue of request beats still to go out
    bit          mBusy [NTAGS];
    int          mAge  [NTAGS];
    logic [3:0]  mCmd  [NTAGS];
    logic [31:0] mOp1  [NTAGS];
    logic [31:0] mOp2  [NTAGS];
    beat_t       mCur, mBeat;
    beat_t       mPend [$];
    int          mFreeTag, mExpTag;
    bit          mReadyNow;
    bit          eCplValid, eCplTimeout, eErrUnexp, eErrTimeout;
    logic [1:0]  eCplTag, eCplResp;
    logic [3:0]  eCplCmd;
    logic [31:0] eCplOp1, eCplOp2, eCplData;
    bit          expFree;
    int          expOut;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAGS; i++) begin
                mBusy[i] = 0; mAge[i] = 0; mCmd[i] = '0; mOp1[i] = '0; mOp2[i] = '0;
            end
            mCur = '0;
            mPend.delete();
            eCplValid = 0; eCplTimeout = 0; eErrUnexp = 0; eErrTimeout = 0;
            eCplTag = '0; eCplResp = '0; eCplCmd = '0; eCplOp1 = '0; eCplOp2 = '0; eCplData = '0;
        end else begin
            mFreeTag = -1;
            for (int i = NTAGS - 1; i >= 0; i--) if (!mBusy[i]) mFreeTag = i;
            mReadyNow = (mPend.size() == 0) && (mFreeTag >= 0);
            eCplValid = 0;
            if (resp_in != 2'd0) begin
                if (resp_in != 2'd3 && mBusy[tag_in]) begin
                    eCplValid = 1; eCplTag = tag_in; eCplResp = resp_in; eCplData = data_in; eCplTimeout = 0;
                end else begin
                    eErrUnexp = 1;
                end
            end
            if (!eCplValid) begin
                mExpTag = -1;
                for (int i = NTAGS - 1; i >= 0; i--) if (mBusy[i] && mAge[i] >= TIMEOUT) mExpTag = i;
                if (mExpTag >= 0) begin
                    eCplValid = 1; eCplTag = 2'(mExpTag); eCplResp = '0; eCplData = '0;
                    eCplTimeout = 1; eErrTimeout = 1;
                end
            end
            if (eCplValid) begin
                eCplCmd = mCmd[eCplTag]; eCplOp1 = mOp1[eCplTag]; eCplOp2 = mOp2[eCplTag];
                mBusy[eCplTag] = 0;
            end
            for (int i = 0; i < NTAGS; i++) if (mBusy[i]) mAge[i]++;
            if (in_valid && mReadyNow) begin
                mBusy[mFreeTag] = 1; mAge[mFreeTag] = 0;
                mCmd[mFreeTag] = in_cmd; mOp1[mFreeTag] = in_op1; mOp2[mFreeTag] = in_op2;
                mCur.cmd = in_cmd; mCur.data = in_op1; mCur.tag = 2'(mFreeTag);
                mBeat.cmd = '0; mBeat.data = in_op2; mBeat.tag = '0;
                mPend.push_back(mBeat);
            end else if (mPend.size() > 0) begin
                mCur = mPend.pop_front();
            end else begin
                mCur = '0;
            end
        end
    end

    always @(negedge c_clk) begin
        expFree = 0;
        expOut  = 0;
        for (int i = 0; i < NTAGS; i++) begin
            if (mBusy[i]) expOut++;
            else expFree = 1;
        end
        checkOutput("in_ready", in_ready, reset && expFree && (mPend.size() == 0));
        checkOutput("req_cmd_out", req_cmd_out, mCur.cmd);
        checkOutput("req_data_out", req_data_out, mCur.data);
        checkOutput("req_tag_out", req_tag_out, mCur.tag);
        checkOutput("cpl_valid", cpl_valid, eCplValid);
        if (eCplValid) begin
            checkOutput("cpl_tag", cpl_tag, eCplTag);
            checkOutput("cpl_cmd", cpl_cmd, eCplCmd);
            checkOutput("cpl_op1", cpl_op1, eCplOp1);
            checkOutput("cpl_op2", cpl_op2, eCplOp2);
            checkOutput("cpl_resp", cpl_resp, eCplResp);
            checkOutput("cpl_data", cpl_data, eCplData);
            checkOutput("cpl_timeout", cpl_timeout, eCplTimeout);
        end
        checkOutput("err_unexp", err_unexp, eErrUnexp);
        checkOutput("err_timeout", err_timeout, eErrTimeout);
        checkOutput("outstanding", outstanding, expOut);
    end

    task automatic nextCycle();
        @(negedge c_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] cmd, input logic [31:0] a,
                                 input logic [31:0] b, input logic [1:0] r, input logic [31:0] d,
                                 input logic [1:0] t);
        in_valid = v; in_cmd = cmd; in_op1 = a; in_op2 = b;
        resp_in = r; data_in = d; tag_in = t;
    endtask

    logic [3:0] satCmd  [5] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1};
    logic [1:0] satResp [5] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd2};
    logic [3:0] cmdList [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6};
    int         waited;
    int         k;
    logic [1:0] r;

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        repeat (2) @(negedge c_clk);
        #1;
        checkOutput("reset_outstanding", outstanding, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_req_cmd", req_cmd_out, 0);
        reset = 1'b1;
        #1;
        checkOutput("release_in_ready", in_ready, 1);

        // Single add
        nextCycle(); applyStimulus(1, 4'd1, 32'd5, 32'd7, 0, 0, 0);
        nextCycle();
        checkOutput("add_send1_cmd", req_cmd_out, 1);
        checkOutput("add_send1_data", req_data_out, 5);
        checkOutput("add_send1_tag", req_tag_out, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("add_send2_cmd", req_cmd_out, 0);
        checkOutput("add_send2_data", req_data_out, 7);
        applyStimulus(0, 0, 0, 0, 2'd1, 32'd12, 2'd0);
        nextCycle();
        checkOutput("add_cpl_valid", cpl_valid, 1);
        checkOutput("add_cpl_tag", cpl_tag, 0);
        checkOutput("add_cpl_data", cpl_data, 12);
        checkOutput("add_cpl_resp", cpl_resp, 1);
        checkOutput("add_outstanding", outstanding, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Saturation: four tags back to back, fifth packet waits for tag 2
        for (int j = 0; j <= 13; j++) begin
            nextCycle();
            if (j % 2 == 1 && j <= 7) checkOutput("sat_issue_tag", req_tag_out, (j - 1) / 2);
            if (j == 8) begin
                checkOutput("sat_outstanding", outstanding, 4);
                checkOutput("sat_ready_low", in_ready, 0);
            end
            if (j == 9) begin
                checkOutput("sat_cpl_tag2", cpl_tag, 2);
                checkOutput("sat_ready_again", in_ready, 1);
            end
            if (j == 10) begin
                checkOutput("sat_realloc_tag", req_tag_out, 2);
                checkOutput("sat_expiring_resp_tag", cpl_tag, 0);
                checkOutput("sat_expiring_resp_not_timeout", cpl_timeout, 0);
            end
            k = (j < 8) ? j / 2 : 4;
            r = (j >= 8 && j <= 12) ? 2'd1 : 2'd0;
            applyStimulus(j <= 9, satCmd[k], 32'd100 + 32'(k), 32'd200 + 32'(k), r,
                          32'h1000 + 32'(j), (j >= 8 && j <= 12) ? satResp[j - 8] : 2'd0);
        end

        // Timeout of a lone packet
        nextCycle();
        checkOutput("pre_timeout_err", err_timeout, 0);
        applyStimulus(1, 4'd2, 32'hAAAA, 32'hBBBB, 0, 0, 0);
        waited = 21;
        for (int n = 1; n <= 20; n++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            if (cpl_valid) begin
                waited = n;
                break;
            end
        end
        checkOutput("timeout_latency", waited, 10);
        checkOutput("timeout_flag", cpl_timeout, 1);
        checkOutput("timeout_resp", cpl_resp, 0);
        checkOutput("timeout_data", cpl_data, 0);
        checkOutput("timeout_sticky", err_timeout, 1);
        checkOutput("timeout_outstanding", outstanding, 0);

        // Unexpected responses
        checkOutput("pre_unexp_err", err_unexp, 0);
        applyStimulus(0, 0, 0, 0, 2'd1, 32'h99, 2'd3);
        nextCycle();
        checkOutput("unexp_free_tag_err", err_unexp, 1);
        checkOutput("unexp_free_tag_no_cpl", cpl_valid, 0);
        applyStimulus(1, 4'd5, 32'h11, 32'h22, 0, 0, 0);
        nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle(); applyStimulus(0, 0, 0, 0, 2'd3, 32'h33, 2'd0);
        nextCycle();
        checkOutput("unexp_resp3_no_cpl", cpl_valid, 0);
        checkOutput("unexp_resp3_still_busy", outstanding, 1);
        applyStimulus(0, 0, 0, 0, 2'd2, 32'h55, 2'd0);
        nextCycle();
        checkOutput("unexp_late_cpl", cpl_valid, 1);
        checkOutput("unexp_late_resp", cpl_resp, 2);
        checkOutput("unexp_late_data", cpl_data, 32'h55);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Collision: tag 0 expires on the edge tag 1's response lands
        for (int j = 0; j <= 11; j++) begin
            nextCycle();
            if (j == 10) begin
                checkOutput("coll_first_tag", cpl_tag, 1);
                checkOutput("coll_first_not_timeout", cpl_timeout, 0);
                checkOutput("coll_first_outstanding", outstanding, 1);
            end
            if (j == 11) begin
                checkOutput("coll_second_valid", cpl_valid, 1);
                checkOutput("coll_second_tag", cpl_tag, 0);
                checkOutput("coll_second_timeout", cpl_timeout, 1);
            end
            applyStimulus(j == 0 || j == 2, (j == 0) ? 4'd1 : 4'd5, 32'h300 + 32'(j), 32'h400 + 32'(j),
                          (j == 9) ? 2'd1 : 2'd0, 32'h77, (j == 9) ? 2'd1 : 2'd0);
        end

        // Reset in the middle of SEND1 with two tags busy
        for (int j = 0; j <= 3; j++) begin
            nextCycle();
            applyStimulus(j == 0 || j == 2, 4'd2, 32'h500, 32'h600, 0, 0, 0);
        end
        checkOutput("rst_pre_outstanding", outstanding, 2);
        checkOutput("rst_pre_tag", req_tag_out, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        checkOutput("rst_req_cmd", req_cmd_out, 0);
        checkOutput("rst_req_data", req_data_out, 0);
        checkOutput("rst_outstanding", outstanding, 0);
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("rst_release_ready", in_ready, 1);
        applyStimulus(1, 4'd6, 32'h9, 32'hA, 0, 0, 0);
        nextCycle();
        checkOutput("rst_next_tag", req_tag_out, 0);
        checkOutput("rst_next_cmd", req_cmd_out, 6);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            nextCycle();
            r = 2'd0;
            if ($urandom_range(0, 99) < 35) begin
                r = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(1, 2));
            end
            applyStimulus($urandom_range(0, 99) < 60, cmdList[$urandom_range(0, 4)], $urandom, $urandom,
                          r, $urandom, 2'($urandom_range(0, 3)));
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (3) nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/calc_port_driver.md
Name: calc_port_driver

Overview:
- Synthesizable request driver for one calc2 port; four instances sit directly upstream of the calc2 DUT wrapper, one per port.
- Accepts operand packets over a valid/ready interface and allocates a free 2-bit tag.
- Serializes each packet onto the DUT's two-cycle cmd/data/tag protocol.
- Matches DUT responses back to their packets by tag, emits one completion per packet, and flags protocol errors and timeouts.

Parameters:
MAX_OUTST, 4, tags in use (1..4); tags 0..MAX_OUTST-1 are allocated
TIMEOUT, 64, cycles from issue with no response before a tag is force-retired

Ports:
c_clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream packet valid
in_ready  out  1  driver can accept a packet this cycle
in_cmd  in  4  calc2 command (0 no-op, 1 add, 2 sub, 5 shl, 6 shr)
in_op1  in  32  operand 1
in_op2  in  32  operand 2
req_cmd_out  out  4  to DUT reqN_cmd_in
req_data_out  out  32  to DUT reqN_data_in
req_tag_out  out  2  to DUT reqN_tag_in
resp_in  in  2  from DUT out_respN (0 none, 1 ok, 2 ovf/invalid, 3 unused)
data_in  in  32  from DUT out_dataN
tag_in  in  2  from DUT out_tagN
cpl_valid  out  1  completion strobe, one cycle
cpl_tag  out  2  tag of completed packet
cpl_cmd  out  4  stored cmd
cpl_op1  out  32  stored op1
cpl_op2  out  32  stored op2
cpl_resp  out  2  DUT response; 0 when timed out
cpl_data  out  32  DUT result; 0 when timed out
cpl_timeout  out  1  completion is a forced timeout retire
err_unexp  out  1  sticky: response for a non-busy tag, or resp_in==3
err_timeout  out  1  sticky: any timeout occurred
outstanding  out  3  busy tag count

Behaviour:
- Reset (reset==0, asynchronous):
  - All outputs 0, FSM to IDLE, all tags free, all timers 0, sticky errors cleared.
  - Any in-flight packet is discarded with no completion.
- FSM states: IDLE, SEND1, SEND2. All DUT-facing outputs are registered.
- IDLE: req_* = 0.
- SEND1: req_cmd_out = cmd, req_data_out = op1, req_tag_out = allocated tag.
- SEND2: req_cmd_out = 0, req_data_out = op2, req_tag_out = 0.
- in_ready = (state != SEND1) && a free tag exists (free status evaluated before the current edge).
- Handshake: accept when in_valid && in_ready at edge k.
  - SEND1 in cycle k+1, SEND2 in cycle k+2.
  - Accept during SEND2 gives SEND1 at k+3 (back-to-back, no bubble).
  - No accept: SEND2 returns to IDLE.
- Allocation: lowest-numbered free tag < MAX_OUTST.
  - At accept, the tag is marked busy; cmd/op1/op2 are stored in the tag table and the timer is cleared.
- Timers: each busy tag increments every cycle, saturating at TIMEOUT.
- Response capture: when resp_in != 0 on an edge:
  - Tag busy and resp_in ∈ {1,2]: next cycle cpl_valid = 1 with stored fields, cpl_resp = resp_in, cpl_data = data_in, cpl_timeout = 0; tag freed.
  - Tag not busy, or resp_in == 3: set err_unexp; no completion; tag state unchanged.
- Timeout: a tag whose timer == TIMEOUT retires in a cycle with no valid response capture.
  - Completion has cpl_timeout = 1, cpl_resp = 0, cpl_data = 0; err_timeout is set; tag freed.
  - Several expired tags retire one per cycle, lowest index first.
- Simultaneous events:
  - DUT response beats timeout; the timeout fires on the next free cycle.
  - Response arriving for a tag in the same cycle that tag expires counts as a normal response.
- A tag freed at edge k is allocatable from cycle k+1, never at edge k itself.
- At most one completion per cycle; completions are registered with latency 1 from the response edge; no backpressure.
- outstanding = popcount of busy tags, updated on the same edge as allocate/free.
- All fields pass through unchanged; no arithmetic on operands.

Decomposition:
- Package calc_pkg: cmd enum (NOP=0, ADD=1, SUB=2, SHL=5, SHR=6), resp enum (NONE, OK, ERR, UNUSED), tag_t (2-bit), pkt_t struct {cmd, op1, op2}.
- One sub-module, calc_tag_table: busy bits, stored pkt_t, per-tag timers, lowest-free and lowest-expired encoders.

Test Plan:
- Single add: in_cmd=1, op1=5, op2=7 accepted at edge 0 → cycle1 req=(1,5,tag0), cycle2 req=(0,7,0); DUT resp 1/data 12/tag 0 → next cycle cpl_valid, cpl_tag=0, cpl_data=12, cpl_resp=1.
- Saturation (MAX_OUTST=4): 5 packets with in_valid held → tags 0,1,2,3 issued back-to-back (SEND1/SEND2 alternating, no bubble); in_ready low after 4th accept, outstanding=4; response for tag 2 → next accept gets tag 2.
- Timeout (TIMEOUT=8): issue one packet with no response → cpl_timeout=1, cpl_resp=0, err_timeout=1, outstanding back to 0.
- Unexpected response: resp_in=1, tag_in=3 while tag 3 free → err_unexp=1, no cpl_valid; also resp_in=3 on busy tag 0 → err_unexp, tag 0 stays busy.
- Collision: tag 0 expires in the same cycle tag 1's response arrives → tag 1 completion first, tag 0 timeout one cycle later.
- Reset mid-SEND1 with 2 tags busy → all outputs 0 immediately, outstanding=0, in_ready=1 after release, next packet gets tag 0.
